// File: rtl/arilla_bus_if.sv
// arilla_bus_if: shared arilla bus seen by one initiator and its responders.
// master drives address/byte_enable/data_ctp/read/write; slave drives hit/data_ptc/intercept.
interface arilla_bus_if #(
  parameter int AddressWidth = 30,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0] address;
  logic [DataWidth/8-1:0]  byte_enable;
  logic [DataWidth-1:0]    data_ctp;
  logic [DataWidth-1:0]    data_ptc;
  logic                    read;
  logic                    write;
  logic                    hit;
  logic                    intercept;

  modport master (
    output address,
    output byte_enable,
    output data_ctp,
    output read,
    output write,
    input  hit,
    input  data_ptc,
    input  intercept
  );

  modport slave (
    input  address,
    input  byte_enable,
    input  data_ctp,
    input  read,
    input  write,
    output hit,
    output data_ptc,
    output intercept
  );
endinterface

// File: rtl/arilla_bus_initiator.sv
// arilla_bus_initiator: turns byte-addressed load/store requests into
// single-word arilla bus transactions and returns aligned, extended data.
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   req_valid/req_ready, req_write, req_size, req_unsigned,
//   req_address (byte), req_wdata (right-aligned)
//   rsp_valid/rsp_ready, rsp_error, rsp_rdata
//   bus_interface : arilla_bus_if.master
//
// Option: ARILLA_INITIATOR_REQ_BUF_EN adds a one-entry request buffer so a
// new request can be accepted while another one is in flight.
module arilla_bus_initiator #(
  parameter int AddressWidth = 30,
  parameter int DataWidth    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [AddressWidth+1:0] req_address,
  input  logic [DataWidth-1:0]    req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_error,
  output logic [DataWidth-1:0]    rsp_rdata,
  arilla_bus_if.master            bus_interface
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_READ_WAIT = 2'd2;
  localparam logic [1:0] S_RESP      = 2'd3;

  typedef struct packed {
    logic                    wr;
    logic [1:0]              size;
    logic                    uns;
    logic [AddressWidth+1:0] addr;
    logic [DataWidth-1:0]    wdata;
  } req_t;

  logic [1:0]           state_q;
  req_t                 cur_q;
  req_t                 in_req;
  req_t                 launch_req;
  logic                 launch;
  logic                 launch_ok;
  logic                 accept;
  logic                 rsp_hs;
  logic                 err_q;
  logic                 hit_q;
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] shifted;
  logic [DataWidth-1:0] load_data;
  logic                 sx;

  function automatic logic legal(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign in_req = '{
    wr:    req_write,
    size:  req_size,
    uns:   req_unsigned,
    addr:  req_address,
    wdata: req_wdata
  };

  assign accept    = req_valid & req_ready;
  assign rsp_hs    = (state_q == S_RESP) & rsp_ready;
  assign launch_ok = legal(launch_req.size, launch_req.addr[1:0]);

`ifdef ARILLA_INITIATOR_REQ_BUF_EN
  req_t buf_q;
  logic buf_full_q;
  logic fsm_free;

  // The FSM can take a new request when idle or when the current
  // response is handed over; a held request always goes first.
  assign fsm_free   = (state_q == S_IDLE) | rsp_hs;
  assign req_ready  = rst_n & ~buf_full_q;
  assign launch     = fsm_free & (buf_full_q | accept);
  assign launch_req = buf_full_q ? buf_q : in_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else if (fsm_free & buf_full_q) begin
      buf_full_q <= 1'b0;
    end else if (accept & ~fsm_free) begin
      buf_full_q <= 1'b1;
      buf_q      <= in_req;
    end
  end
`else
  assign req_ready  = rst_n & (state_q == S_IDLE);
  assign launch     = accept;
  assign launch_req = in_req;
`endif

  // Load path: bring the addressed lane down to bit 0, then extend.
  assign shifted = bus_interface.data_ptc >> {cur_q.addr[1:0], 3'b000};
  assign sx      = ~cur_q.uns;

  always_comb begin
    load_data = shifted;
    unique case (1'b1)
      cur_q.size == 2'b00:
        load_data = {{(DataWidth-8){sx & shifted[7]}}, shifted[7:0]};
      cur_q.size == 2'b01:
        load_data = {{(DataWidth-16){sx & shifted[15]}}, shifted[15:0]};
      default:
        load_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (launch) begin
            cur_q   <= launch_req;
            state_q <= launch_ok ? S_ISSUE : S_RESP;
            err_q   <= ~launch_ok;
            rdata_q <= '0;
          end
        end
        S_ISSUE: begin
          hit_q <= bus_interface.hit;
          if (cur_q.wr) begin
            state_q <= S_RESP;
            err_q   <= ~bus_interface.hit;
            rdata_q <= '0;
          end else begin
            state_q <= S_READ_WAIT;
          end
        end
        S_READ_WAIT: begin
          // A missed read leaves data_ptc undriven; never let it through.
          state_q <= S_RESP;
          err_q   <= ~hit_q;
          rdata_q <= hit_q ? load_data : '0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            if (launch) begin
              cur_q   <= launch_req;
              state_q <= launch_ok ? S_ISSUE : S_RESP;
              err_q   <= ~launch_ok;
              rdata_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_error = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;

  always_comb begin
    bus_interface.address     = '0;
    bus_interface.byte_enable = '0;
    bus_interface.data_ctp    = '0;
    bus_interface.read        = 1'b0;
    bus_interface.write       = 1'b0;
    if (state_q == S_ISSUE) begin
      bus_interface.address = cur_q.addr[AddressWidth+1:2];
      bus_interface.read    = ~cur_q.wr;
      bus_interface.write   = cur_q.wr;
      unique case (1'b1)
        cur_q.size == 2'b00: begin
          bus_interface.byte_enable = 4'b0001 << cur_q.addr[1:0];
          bus_interface.data_ctp    = {4{cur_q.wdata[7:0]}};
        end
        cur_q.size == 2'b01: begin
          bus_interface.byte_enable = 4'b0011 << cur_q.addr[1:0];
          bus_interface.data_ctp    = {2{cur_q.wdata[15:0]}};
        end
        default: begin
          bus_interface.byte_enable = 4'b1111;
          bus_interface.data_ctp    = cur_q.wdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arilla_bus_initiator.sv
// tb_arilla_bus_initiator: random and directed load/store traffic against
// a byte-level reference memory, with a simple word responder on the bus.
module tb_arilla_bus_initiator;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_address;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_error;
  logic [DW-1:0] rsp_rdata;

  always #5 clk = ~clk;

  arilla_bus_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

  arilla_bus_initiator #(.AddressWidth(AW), .DataWidth(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_address   (req_address),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_error     (rsp_error),
    .rsp_rdata     (rsp_rdata),
    .bus_interface (bus)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Responder: 256 words at byte 0x000-0x3FF, read data one cycle later.
  logic        mem_init;
  logic [31:0] mem [256];
  logic [31:0] ptc_q;

  assign bus.hit       = (bus.read | bus.write) & (bus.address[AW-1:8] == '0);
  assign bus.data_ptc  = ptc_q;
  assign bus.intercept = 1'b0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (bus.write && bus.hit) begin
      for (int b = 0; b < 4; b++)
        if (bus.byte_enable[b])
          mem[bus.address[7:0]][8*b +: 8] <= bus.data_ctp[8*b +: 8];
    end
    ptc_q <= (bus.read && bus.hit) ? mem[bus.address[7:0]] : 32'hDEAD0BAD;
  end

  logic [7:0] rmem [1024];
  int n_err = 0;
  int n_chk = 0;
  logic [31:0] last_rdata;
  logic [3:0]  last_be;
  logic [31:0] last_ctp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte memory plus the access rules, stores applied on success.
  task automatic model(input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       output logic [31:0] e_rd, output logic e_err,
                       output logic [3:0] e_be, output logic [31:0] e_ctp,
                       output int e_lat, output int e_stb);
    int nb;
    int off;
    logic [31:0] v;
    nb = 1 << size;
    off = int'(addr % 4);
    e_rd = 0;
    e_be = 0;
    e_ctp = 0;
    if (size == 2'b11 || (addr % nb) != 0) begin
      e_err = 1'b1;
      e_lat = 1;
      e_stb = 0;
      return;
    end
    e_stb = 1;
    e_lat = wr ? 2 : 3;
    e_err = (addr >= 1024);
    for (int k = 0; k < nb; k++) e_be[off+k] = 1'b1;
    for (int i = 0; i < 4; i++) e_ctp[8*i +: 8] = wdata[8*(i % nb) +: 8];
    if (e_err) return;
    if (wr) begin
      for (int k = 0; k < nb; k++) rmem[addr+k] = wdata[8*k +: 8];
    end else begin
      v = 0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = rmem[addr+k];
      if (!uns && nb < 4 && v[8*nb-1])
        for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
      e_rd = v;
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        input string tag);
    logic [31:0] e_rd, e_ctp, s_ctp;
    logic        e_err, s_wr;
    logic [3:0]  e_be, s_be;
    logic [AW-1:0] s_addr;
    int e_lat, e_stb, got_lat, nstb, stb_cyc;
    model(wr, size, uns, addr, wdata, e_rd, e_err, e_be, e_ctp, e_lat, e_stb);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_size = size;
    req_unsigned = uns;
    req_address = addr;
    req_wdata = wdata;
    chk({tag, ".rdy"}, req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got_lat = 0;
    nstb = 0;
    stb_cyc = 0;
    s_addr = '0;
    s_be = '0;
    s_ctp = '0;
    s_wr = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.read || bus.write) begin
        nstb++;
        stb_cyc = c;
        s_addr = bus.address;
        s_be = bus.byte_enable;
        s_ctp = bus.data_ctp;
        s_wr = bus.write;
      end
      if (rsp_valid) begin
        got_lat = c;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ".lat"}, got_lat, e_lat);
    chk({tag, ".nstb"}, nstb, e_stb);
    if (e_stb == 1) begin
      chk({tag, ".stbcyc"}, stb_cyc, 1);
      chk({tag, ".addr"}, 32'(s_addr), addr >> 2);
      chk({tag, ".be"}, s_be, e_be);
      chk({tag, ".dir"}, s_wr, wr);
      if (wr) chk({tag, ".ctp"}, s_ctp, e_ctp);
    end
    chk({tag, ".err"}, rsp_error, e_err);
    chk({tag, ".rdata"}, rsp_rdata, e_rd);
    last_rdata = rsp_rdata;
    last_be = s_be;
    last_ctp = s_ctp;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_v"}, rsp_valid, 1'b1);
      chk({tag, ".hold_d"}, rsp_rdata, e_rd);
      chk({tag, ".hold_e"}, rsp_error, e_err);
      chk({tag, ".hold_s"}, bus.read | bus.write, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".done"}, rsp_valid, 1'b0);
  endtask

  initial begin
    logic        wr, uns;
    logic [1:0]  size;
    logic [31:0] addr;
    int r;

    rst_n = 1'b0;
    mem_init = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_address = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++)
      for (int b = 0; b < 4; b++) rmem[4*i+b] = init_word(i) >> (8*b);

    @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", req_ready, 1'b0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.rsp_error", rsp_error, 1'b0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.read", bus.read, 1'b0);
    chk("rst.write", bus.write, 1'b0);
    chk("rst.be", bus.byte_enable, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    rst_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, "st_w");
    chk("plan.st_w.addr_be", {28'h0, last_be}, 32'hF);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, "ld_w");
    chk("plan.ld_w", last_rdata, 32'hDEADBEEF);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF0000, 0, "st_w2");
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, "lb_s");
    chk("plan.lb_s", last_rdata, 32'hFFFFFF80);
    chk("plan.lb_s.be", {28'h0, last_be}, 32'h8);
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, "lb_u");
    chk("plan.lb_u", last_rdata, 32'h00000080);
    do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 0, "sh");
    chk("plan.sh.ctp", last_ctp, 32'h12341234);
    chk("plan.sh.be", {28'h0, last_be}, 32'hC);
    do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, "lh");
    chk("plan.lh", last_rdata, 32'h00001234);
    do_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 0, "miss");
    do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, "misal");
    do_req(1'b1, 2'b11, 1'b0, 32'h100, 32'h55, 0, "rsvd");
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5, "hold");

    // Reset while the read strobe is out.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'b10;
    req_address = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.read_before", bus.read, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid.read", bus.read, 1'b0);
    chk("rstmid.rsp_valid", rsp_valid, 1'b0);
    chk("rstmid.req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid.idle", req_ready, 1'b1);
    chk("rstmid.no_rsp", rsp_valid, 1'b0);

`ifdef ARILLA_INITIATOR_REQ_BUF_EN
    begin
      logic [31:0] ea, eb, d_ctp;
      logic        d_err;
      logic [3:0]  d_be;
      int d_lat, d_stb;
      int rd_c[$];
      int rs_c[$];
      logic [31:0] rs_d[$];
      model(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, ea, d_err, d_be, d_ctp, d_lat, d_stb);
      model(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, eb, d_err, d_be, d_ctp, d_lat, d_stb);
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size = 2'b10;
      req_address = 32'h100;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (c == 1) begin
          chk("buf.rdy1", req_ready, 1'b1);
          req_address = 32'h104;
        end
        if (c == 2) req_valid = 1'b0;
        if (bus.read) rd_c.push_back(c);
        if (rsp_valid) begin
          rs_c.push_back(c);
          rs_d.push_back(rsp_rdata);
        end
      end
      rsp_ready = 1'b0;
      chk("buf.nrd", rd_c.size(), 2);
      chk("buf.nrsp", rs_c.size(), 2);
      if (rd_c.size() == 2 && rs_c.size() == 2) begin
        chk("buf.rd0", rd_c[0], 1);
        chk("buf.rd1", rd_c[1], 4);
        chk("buf.rs0", rs_c[0], 3);
        chk("buf.rs1", rs_c[1], 6);
        chk("buf.d0", rs_d[0], ea);
        chk("buf.d1", rs_d[1], eb);
      end
    end
`endif

    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      r = int'($urandom % 8);
      size = (r < 7) ? 2'(r % 3) : 2'b11;
      addr = $urandom_range(0, 2047);
      if (($urandom % 4) != 0 && size != 2'b11)
        addr = addr & ~((32'd1 << size) - 1);
      do_req(wr, size, uns, addr, $urandom, int'($urandom % 3), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
